// File: rtl/mdu_pkg.sv
// Shared op codes, FSM encoding and op-decode helpers for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } mdu_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift the next dividend bit into the remainder and trial-subtract.
module mdu_divstep
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;
  logic           fits;

  always_comb begin
    shifted = {rem_in, quo_in[WIDTH-1]};
    fits    = (shifted >= {1'b0, divisor});
    rem_out = fits ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
    quo_out = {quo_in[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed/unsigned multiply/divide unit driving HI/LO, with start/done handshake,
// divide-by-zero flagging and direct HI/LO writes while idle.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned ACC_W = 2 * WIDTH;

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             div_q, div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [ACC_W-1:0] mul_next, prod_fix;
  logic [WIDTH-1:0] rem_nx, quo_nx, quo_fix, rem_fix;

  // acc holds {remainder, quotient} for divide and {partial product, multiplier} for multiply
  mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_in  (acc_q[ACC_W-1:WIDTH]),
    .quo_in  (acc_q[WIDTH-1:0]),
    .divisor (opnd_q),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  always_comb begin
    a_neg    = op_is_signed(op) & op_a[WIDTH-1];
    b_neg    = op_is_signed(op) & op_b[WIDTH-1];
    abs_a    = a_neg ? (~op_a + WIDTH'(1)) : op_a;
    abs_b    = b_neg ? (~op_b + WIDTH'(1)) : op_b;
    mul_sum  = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    prod_fix = neg_q ? (~acc_q + ACC_W'(1)) : acc_q;
    quo_fix  = neg_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    rem_fix  = rneg_q ? (~acc_q[ACC_W-1:WIDTH] + WIDTH'(1)) : acc_q[ACC_W-1:WIDTH];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (hi_wr) hi_d = wr_data;
        if (lo_wr) lo_d = wr_data;
        if (start) begin
          if (op_is_div(op) && (op_b == '0)) begin
            done_d = 1'b1;
            dz_d   = 1'b1;
          end else begin
            acc_d   = {{WIDTH{1'b0}}, abs_a};
            opnd_d  = abs_b;
            div_d   = op_is_div(op);
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
            cnt_d   = CNT_W'(WIDTH);
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        acc_d = div_q ? {rem_nx, quo_nx} : mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        hi_d    = div_q ? rem_fix : prod_fix[ACC_W-1:WIDTH];
        lo_d    = div_q ? quo_fix : prod_fix[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (WIDTH=32).
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        hi_wr = 1'b0;
  logic        lo_wr = 1'b0;
  logic [31:0] wr_data = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .hi_wr(hi_wr), .lo_wr(lo_wr), .wr_data(wr_data),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; op_a = a; op_b = b;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (done !== 1'b0 || div_zero !== 1'b0) begin errors++; $display("FAIL reset_flags: got done=%b dz=%b exp 0", done, div_zero); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL reset_hilo: got hi=%h lo=%h exp 0", hi, lo); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    int lat;
    issue(MDU_MULT, 32'hFFFFFFFD, 32'h00000007);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mult_busy: got %b exp 1", busy); end
    wait_done(lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mult_latency: got %0d exp 33", lat); end
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_result: got %h_%h exp ffffffff_ffffffeb", hi, lo); end
    checks++; if (busy !== 1'b0 || div_zero !== 1'b0) begin errors++; $display("FAIL mult_done_state: got busy=%b dz=%b exp 0 0", busy, div_zero); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b exp 0", done); end
    issue(MDU_MULT, 32'h00000006, 32'hFFFFFFFE);
    wait_done(lat);
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF4) begin errors++; $display("FAIL mult_neg_b: got %h_%h exp ffffffff_fffffff4", hi, lo); end
    tick();
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat);
    checks++; if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin errors++; $display("FAIL multu_result: got %h_%h exp fffffffe_00000001", hi, lo); end
    issue(MDU_MULTU, 32'h00000003, 32'h00000005);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b exp 1", busy); end
    wait_done(lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency: got %0d exp 33", lat); end
    checks++; if (hi !== 32'h0 || lo !== 32'd15) begin errors++; $display("FAIL b2b_result: got %h_%h exp 00000000_0000000f", hi, lo); end
    tick();
  endtask

  task automatic test_div();
    int lat;
    issue(MDU_DIV, 32'hFFFFFFF9, 32'h00000002);
    wait_done(lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency: got %0d exp 33", lat); end
    checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_a: got lo=%h hi=%h exp fffffffd ffffffff", lo, hi); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL div_nozero: got %b exp 0", div_zero); end
    tick();
    issue(MDU_DIV, 32'h00000007, 32'hFFFFFFFE);
    wait_done(lat);
    checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'h00000001) begin errors++; $display("FAIL div_neg_b: got lo=%h hi=%h exp fffffffd 00000001", lo, hi); end
    tick();
    issue(MDU_DIVU, 32'h00000007, 32'h00000002);
    wait_done(lat);
    checks++; if (lo !== 32'h3 || hi !== 32'h1) begin errors++; $display("FAIL divu_small: got lo=%h hi=%h exp 3 1", lo, hi); end
    tick();
    issue(MDU_DIVU, 32'hFFFFFFFF, 32'h0000000A);
    wait_done(lat);
    checks++; if (lo !== 32'h19999999 || hi !== 32'h5) begin errors++; $display("FAIL divu_large: got lo=%h hi=%h exp 19999999 5", lo, hi); end
    tick();
    issue(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat);
    checks++; if (lo !== 32'h80000000 || hi !== 32'h0) begin errors++; $display("FAIL div_minint: got lo=%h hi=%h exp 80000000 0", lo, hi); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL div_minint_flag: got %b exp 0", div_zero); end
    tick();
  endtask

  task automatic test_div_zero();
    lo_wr = 1'b1; wr_data = 32'h12345678;
    tick();
    lo_wr = 1'b0;
    checks++; if (lo !== 32'h12345678) begin errors++; $display("FAIL mtlo: got %h exp 12345678", lo); end
    issue(MDU_DIVU, 32'h00000005, 32'h00000000);
    checks++; if (done !== 1'b1 || div_zero !== 1'b1) begin errors++; $display("FAIL dz_flags: got done=%b dz=%b exp 1 1", done, div_zero); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dz_busy: got %b exp 0", busy); end
    checks++; if (lo !== 32'h12345678 || hi !== 32'h0) begin errors++; $display("FAIL dz_hilo: got lo=%h hi=%h exp 12345678 0", lo, hi); end
    tick();
    checks++; if (done !== 1'b0 || div_zero !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL dz_after: got done=%b dz=%b busy=%b exp 0 0 0", done, div_zero, busy); end
  endtask

  task automatic test_ignore_busy();
    int lat;
    issue(MDU_MULT, 32'h00000006, 32'hFFFFFFFE);
    repeat (4) tick();
    issue(MDU_MULTU, 32'h00000003, 32'h00000003);
    hi_wr = 1'b1; wr_data = 32'hDEADBEEF;
    tick();
    hi_wr = 1'b0;
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL busy_mthi: got %h exp 0", hi); end
    wait_done(lat);
    checks++; if (lat !== 27) begin errors++; $display("FAIL ignore_latency: got %0d exp 27", lat); end
    checks++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF4) begin errors++; $display("FAIL ignore_result: got %h_%h exp ffffffff_fffffff4", hi, lo); end
    tick();
  endtask

  task automatic test_reset_midop();
    int pulses;
    issue(MDU_DIV, 32'd100, 32'd7);
    repeat (9) tick();
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_ctl: got busy=%b done=%b exp 0 0", busy, done); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL midrst_hilo: got hi=%h lo=%h exp 0 0", hi, lo); end
    tick();
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_done: got %0d pulses exp 0", pulses); end
    checks++; if (busy !== 1'b0 || lo !== 32'h0) begin errors++; $display("FAIL midrst_idle: got busy=%b lo=%h exp 0 0", busy, lo); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_back_to_back();
    test_div();
    test_div_zero();
    test_ignore_busy();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
